// File: rtl/mul_share_sequencer_if.sv
// Purpose: request/response bundle between the two multiply requesters and
//          the shared shift-add multiplier sequencer.
// Ports (as signals):
//   iReq0/iA0/iB0  requester 0 request and operands
//   iReq1/iA1/iB1  requester 1 request and operands
//   oAck0/oAck1    operand-capture pulses
//   oBusy          engine occupied (ack cycle through done cycle)
//   oDone/oDoneId  result-valid pulse and owning requester
//   oResult        2*WIDTH unsigned product, held until the next oDone
// Modports: master = requester side, slave = sequencer side.
interface mul_share_sequencer_if #(
    parameter int WIDTH = 16
);
    logic                 iReq0;
    logic [WIDTH-1:0]     iA0;
    logic [WIDTH-1:0]     iB0;
    logic                 iReq1;
    logic [WIDTH-1:0]     iA1;
    logic [WIDTH-1:0]     iB1;
    logic                 oAck0;
    logic                 oAck1;
    logic                 oBusy;
    logic                 oDone;
    logic                 oDoneId;
    logic [2*WIDTH-1:0]   oResult;

    modport master (
        output iReq0, iA0, iB0, iReq1, iA1, iB1,
        input  oAck0, oAck1, oBusy, oDone, oDoneId, oResult
    );

    modport slave (
        input  iReq0, iA0, iB0, iReq1, iA1, iB1,
        output oAck0, oAck1, oBusy, oDone, oDoneId, oResult
    );
endinterface

// File: rtl/mul_share_sequencer.sv
// Purpose: round-robin arbiter and sequencer for a shared WIDTH x WIDTH
//          shift-add multiplier serving two requesters.
// Ports:
//   Clock  in   system clock, posedge
//   Reset  in   synchronous active-low reset
//   bus    slave modport of mul_share_sequencer_if (requests, operands,
//          acks, busy, done, done id, result)
//
// state | meaning
// IDLE  | sample requests, grant one, capture operands
// RUN   | WIDTH add/shift iterations, one per cycle
// DONE  | publish product and id, pulse oDone, update round-robin pointer
module mul_share_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                   Clock,
    input  logic                   Reset,
    mul_share_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, stateNext;
    logic [2*WIDTH-1:0]   rAcc, accNext;
    logic [WIDTH-1:0]     rMcand, mcandNext;
    logic [WIDTH-1:0]     rMplier, mplierNext;
    logic [CNT_W-1:0]     rCount, countNext;
    logic                 rId, idNext;
    logic                 rPrio, prioNext;   // requester that wins a tie
    logic                 ack0, ack0Next;
    logic                 ack1, ack1Next;
    logic                 busy, busyNext;
    logic                 done, doneNext;
    logic                 doneId, doneIdNext;
    logic [2*WIDTH-1:0]   result, resultNext;
    logic                 grant0, grant1;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            rAcc    <= '0;
            rMcand  <= '0;
            rMplier <= '0;
            rCount  <= '0;
            rId     <= 1'b0;
            rPrio   <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            doneId  <= 1'b0;
            result  <= '0;
        end else begin
            state   <= stateNext;
            rAcc    <= accNext;
            rMcand  <= mcandNext;
            rMplier <= mplierNext;
            rCount  <= countNext;
            rId     <= idNext;
            rPrio   <= prioNext;
            ack0    <= ack0Next;
            ack1    <= ack1Next;
            busy    <= busyNext;
            done    <= doneNext;
            doneId  <= doneIdNext;
            result  <= resultNext;
        end
    end

    always_comb begin
        stateNext  = state;
        accNext    = rAcc;
        mcandNext  = rMcand;
        mplierNext = rMplier;
        countNext  = rCount;
        idNext     = rId;
        prioNext   = rPrio;
        ack0Next   = 1'b0;
        ack1Next   = 1'b0;
        busyNext   = busy;
        doneNext   = 1'b0;
        doneIdNext = doneId;
        resultNext = result;
        grant0     = 1'b0;
        grant1     = 1'b0;

        case (state)
            IDLE: begin
                busyNext = 1'b0;
                grant0   = bus.iReq0 && (!bus.iReq1 || !rPrio);
                grant1   = bus.iReq1 && (!bus.iReq0 || rPrio);
                if (grant0 || grant1) begin
                    mcandNext  = grant1 ? bus.iA1 : bus.iA0;
                    mplierNext = grant1 ? bus.iB1 : bus.iB0;
                    accNext    = '0;
                    countNext  = '0;
                    idNext     = grant1;
                    ack0Next   = grant0;
                    ack1Next   = grant1;
                    busyNext   = 1'b1;
                    stateNext  = RUN;
                end
            end
            RUN: begin
                if (rMplier[0]) begin
                    accNext = rAcc + ({{WIDTH{1'b0}}, rMcand} << rCount);
                end
                mplierNext = rMplier >> 1;
                countNext  = rCount + 1'b1;
                if (rCount == CNT_W'(WIDTH - 1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                resultNext = rAcc;
                doneIdNext = rId;
                doneNext   = 1'b1;
                prioNext   = ~rId;   // the other requester wins the next tie
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.oAck0   = ack0;
    assign bus.oAck1   = ack1;
    assign bus.oBusy   = busy;
    assign bus.oDone   = done;
    assign bus.oDoneId = doneId;
    assign bus.oResult = result;
endmodule

// File: tb/tb_mul_share_sequencer.sv
module tb_mul_share_sequencer;
    localparam int WIDTH = 16;
    localparam int LAT   = 17;   // ack cycle to done cycle

    typedef struct {
        bit          id;
        logic [31:0] prod;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   cyc = 0;
    int   nVec = 0;
    int   nMiss = 0;
    exp_t sbQ[$];
    exp_t monE;
    logic [WIDTH-1:0] opA [2];
    logic [WIDTH-1:0] opB [2];

    mul_share_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mul_share_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .Clock (clk),
        .Reset (rstN),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        if (rstN) begin
            if (bus.oAck0 || bus.oAck1 || bus.oDone)
                chk("ack_done_excl", (bus.oAck0 & bus.oAck1) | ((bus.oAck0 | bus.oAck1) & bus.oDone), 1'b0);
            if (bus.oDone) begin
                if (sbQ.size() == 0) begin
                    chk("spurious_done", 1'b1, 1'b0);
                end else begin
                    monE = sbQ.pop_front();
                    chk("done_id", bus.oDoneId, monE.id);
                    chk("result", bus.oResult, monE.prod);
                    chk("done_latency", cyc, monE.due);
                    chk("busy_at_done", bus.oBusy, 1'b1);
                end
            end else if (sbQ.size() > 0 && cyc > sbQ[0].due) begin
                chk("done_timeout", cyc, sbQ[0].due);
                void'(sbQ.pop_front());
            end
        end
    end

    task automatic setOp(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        opA[id] = a;
        opB[id] = b;
        if (id) begin
            bus.iA1 = a; bus.iB1 = b; bus.iReq1 = 1'b1;
        end else begin
            bus.iA0 = a; bus.iB0 = b; bus.iReq0 = 1'b1;
        end
    endtask

    task automatic waitAck(input bit wantId, input bit drop, output int c);
        bit got = 1'b0;
        bit gid;
        c = -1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.oAck0 || bus.oAck1) begin
                got = 1'b1;
                c   = cyc;
                gid = bus.oAck1;
                chk("grant_id", gid, wantId);
                chk("busy_at_ack", bus.oBusy, 1'b1);
                sbQ.push_back('{gid, 32'(opA[gid]) * 32'(opB[gid]), cyc + LAT});
                if (drop) begin
                    if (gid) bus.iReq1 = 1'b0;
                    else     bus.iReq0 = 1'b0;
                end
            end
        end
        if (!got) begin
            chk("ack_timeout", 1'b0, 1'b1);
            bus.iReq0 = 1'b0;
            bus.iReq1 = 1'b0;
        end
    endtask

    task automatic issue(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit hold, output int rc, output int c);
        @(negedge clk);
        setOp(id, a, b);
        rc = cyc;
        waitAck(id, !hold, c);
    endtask

    task automatic waitIdle();
        bit empty = 1'b0;
        for (int i = 0; i < 60 && !empty; i++) begin
            @(negedge clk);
            empty = (sbQ.size() == 0);
        end
        if (!empty) begin
            chk("idle_timeout", sbQ.size(), 0);
            sbQ.delete();
        end
        @(negedge clk);
        chk("busy_idle", bus.oBusy, 1'b0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rstN = 1'b0;
        sbQ.delete();
        bus.iReq0 = 1'b0;
        bus.iReq1 = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        chk("reset_outputs", {bus.oAck0, bus.oAck1, bus.oBusy, bus.oDone, bus.oDoneId, bus.oResult}, '0);
    endtask

    initial begin
        int rc, c1, c2, c3, c4;
        bus.iReq0 = 1'b0; bus.iA0 = '0; bus.iB0 = '0;
        bus.iReq1 = 1'b0; bus.iA1 = '0; bus.iB1 = '0;
        opA[0] = '0; opA[1] = '0; opB[0] = '0; opB[1] = '0;

        applyReset();

        // single request, small operands
        issue(1'b0, 16'd3, 16'd5, 1'b0, rc, c1);
        chk("ack_latency", c1 - rc, 1);
        chk("product_3x5", 32'(opA[0]) * 32'(opB[0]), 32'h0000000F);
        waitIdle();

        // max operands from requester 1
        issue(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, rc, c1);
        chk("product_max", 32'(opA[1]) * 32'(opB[1]), 32'hFFFE0001);
        waitIdle();

        // zero multiplicand still takes full latency
        issue(1'b0, 16'h0000, 16'h1234, 1'b0, rc, c1);
        waitIdle();

        // held request: two back-to-back ops
        issue(1'b0, 16'd7, 16'd9, 1'b1, rc, c1);
        waitAck(1'b0, 1'b1, c2);
        chk("held_ack_spacing", c2 - c1, 18);
        waitIdle();

        // a few random single ops, last one from requester 0
        for (int i = 0; i < 4; i++) begin
            issue(i[0] ? 1'b0 : 1'b1, 16'($urandom), 16'($urandom), 1'b0, rc, c1);
            waitIdle();
        end

        // reset mid-RUN: abort, no done, then a normal req1 op
        issue(1'b1, 16'h1234, 16'h0077, 1'b0, rc, c1);
        while (cyc < c1 + 7) @(negedge clk);
        rstN = 1'b0;
        sbQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        chk("midrun_reset_outputs", {bus.oAck0, bus.oAck1, bus.oBusy, bus.oDone, bus.oDoneId, bus.oResult}, '0);
        repeat (25) @(negedge clk);
        chk("no_done_after_abort", bus.oResult, '0);
        issue(1'b1, 16'h0102, 16'h0304, 1'b0, rc, c1);
        waitIdle();

        // serve requester 0 last, then reset: priority must return to 0
        issue(1'b0, 16'd11, 16'd13, 1'b0, rc, c1);
        waitIdle();
        applyReset();

        // contention: both held continuously
        @(negedge clk);
        setOp(1'b0, 16'h00A5, 16'h0101);
        setOp(1'b1, 16'h1000, 16'h0020);
        waitAck(1'b0, 1'b0, c1);
        waitAck(1'b1, 1'b0, c2);
        waitAck(1'b0, 1'b0, c3);
        waitAck(1'b1, 1'b0, c4);
        bus.iReq0 = 1'b0;
        bus.iReq1 = 1'b0;
        chk("rr_spacing_1", c2 - c1, 18);
        chk("rr_spacing_2", c3 - c2, 18);
        chk("rr_spacing_3", c4 - c3, 18);
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
